// File: rtl/led_indicator.sv
// Multi-channel LED driver: global PWM brightness, shared phase-aligned blink
// timebase, and a per-channel one-shot flash sequencer.
module led_indicator #(
   parameter int NUM         = 2,
   parameter int PWM_WIDTH   = 8,
   parameter int BLINK_DEPTH = 22,
   parameter int FLASH_DEPTH = 20
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [2*NUM-1:0]     mode_i,
   input  logic [NUM-1:0]       flash_i,
   input  logic [PWM_WIDTH-1:0] brightness_i,
   output logic [NUM-1:0]       led_o,
   output logic [NUM-1:0]       busy_o
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FLASH_ON  = 2'd1,
      FLASH_OFF = 2'd2
   } flash_state_t;

   localparam logic [1:0] MODE_OFF        = 2'd0;
   localparam logic [1:0] MODE_ON         = 2'd1;
   localparam logic [1:0] MODE_BLINK_SLOW = 2'd2;
   localparam logic [1:0] MODE_BLINK_FAST = 2'd3;

   logic [PWM_WIDTH-1:0]   pwm_cnt_reg;
   logic [PWM_WIDTH-1:0]   bri_reg;
   logic [BLINK_DEPTH-1:0] blink_cnt_reg;
   logic                   pwm_on;
   logic                   slow_phase;
   logic                   fast_phase;

   // Brightness is only sampled at the period boundary so a duty change never
   // produces a truncated or stretched pulse.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pwm_cnt_reg   <= '0;
         bri_reg       <= '0;
         blink_cnt_reg <= '0;
      end else begin
         pwm_cnt_reg   <= pwm_cnt_reg + 1'b1;
         blink_cnt_reg <= blink_cnt_reg + 1'b1;
         if (&pwm_cnt_reg) begin
            bri_reg <= brightness_i;
         end
      end
   end

   // Full-scale brightness must be solidly on, which the compare alone cannot give.
   assign pwm_on     = (&bri_reg) ? 1'b1 : (pwm_cnt_reg < bri_reg);
   assign slow_phase = blink_cnt_reg[BLINK_DEPTH-1];
   assign fast_phase = blink_cnt_reg[BLINK_DEPTH-3];

   generate
      for (genvar gi = 0; gi < NUM; gi++) begin : g_chan
         flash_state_t           state_reg, state_next;
         logic [FLASH_DEPTH-1:0] flash_cnt_reg, flash_cnt_next;
         logic                   raw;
         logic                   led_reg;
         logic [1:0]             mode;

         assign mode = mode_i[2*gi +: 2];

         // The counter rolls over to zero exactly when the state advances.
         always_comb begin
            state_next     = state_reg;
            flash_cnt_next = '0;
            case (state_reg)
               IDLE: begin
                  if (flash_i[gi]) begin
                     state_next = FLASH_ON;
                  end
               end
               FLASH_ON: begin
                  flash_cnt_next = flash_cnt_reg + 1'b1;
                  if (&flash_cnt_reg) begin
                     state_next = FLASH_OFF;
                  end
               end
               FLASH_OFF: begin
                  flash_cnt_next = flash_cnt_reg + 1'b1;
                  if (&flash_cnt_reg) begin
                     state_next = IDLE;
                  end
               end
               default: begin
                  state_next = IDLE;
               end
            endcase
         end

         always_comb begin
            raw = 1'b0;
            case (state_reg)
               FLASH_ON:  raw = 1'b1;
               FLASH_OFF: raw = 1'b0;
               default: begin
                  case (mode)
                     MODE_OFF:        raw = 1'b0;
                     MODE_ON:         raw = 1'b1;
                     MODE_BLINK_SLOW: raw = slow_phase;
                     MODE_BLINK_FAST: raw = fast_phase;
                     default:         raw = 1'b0;
                  endcase
               end
            endcase
         end

         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               state_reg     <= IDLE;
               flash_cnt_reg <= '0;
               led_reg       <= 1'b0;
            end else begin
               state_reg     <= state_next;
               flash_cnt_reg <= flash_cnt_next;
               led_reg       <= raw & pwm_on;
            end
         end

         assign led_o[gi]  = led_reg;
         assign busy_o[gi] = (state_reg != IDLE);
      end
   endgenerate

endmodule
